// File: rtl/ram_line_xfer_pkg.sv
// ---------------------------------------------------------------------------
// ram_line_xfer_pkg
// Shared definitions for the cache-line <-> RAM burst engine: beat geometry,
// FSM state encoding and the beat-slice helper. The cache side uses the same
// line width and beat order (beat k = line[16k+15:16k], LSB beat first).
// ---------------------------------------------------------------------------
package ram_line_xfer_pkg;

    localparam int WORD_W = 16;
    localparam int LINE_W = 64;
    localparam int BEATS  = LINE_W / WORD_W;

    // Terminal value of the 2-bit beat counter.
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_BEATS = 3'd1;
    localparam logic [2:0] ST_WR_WAIT  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_RD_BEATS = 3'd4;
    localparam logic [2:0] ST_RESP     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_WR_BEATS = ST_WR_BEATS,
        S_WR_WAIT  = ST_WR_WAIT,
        S_RD_WAIT  = ST_RD_WAIT,
        S_RD_BEATS = ST_RD_BEATS,
        S_RESP     = ST_RESP
    } xfer_state_e;

    // Beat k of a line.
    function automatic logic [WORD_W-1:0] beat_slice(input logic [LINE_W-1:0] line,
                                                     input logic [1:0]        k);
        return line[int'(k)*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/ram_line_beat_shift.sv
// ---------------------------------------------------------------------------
// ram_line_beat_shift
// Line-wide shift/assemble register. A parallel load followed by shifts
// presents the line one beat at a time on beat_o (LSB beat first); shifting
// in read beats at the top assembles a line whose first beat ends up in the
// LSB slot after BEATS shifts.
// Ports:
//   clk_i      clock
//   load_i     parallel load of line_i (priority over shift)
//   shift_i    shift one beat toward the LSB, beat_i entering at the top
//   line_i     line to load
//   beat_i     beat shifted in at the top
//   beat_o     current LSB beat
//   shifted_o  value the register takes on a shift (used to capture the
//              completed read line together with its last beat)
// Holds data only, so it carries no reset.
// ---------------------------------------------------------------------------
module ram_line_beat_shift
    import ram_line_xfer_pkg::*;
(
    input  logic              clk_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic [WORD_W-1:0] beat_i,
    output logic [WORD_W-1:0] beat_o,
    output logic [LINE_W-1:0] shifted_o
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    assign shifted_o = {beat_i, line_q[LINE_W-1:WORD_W]};
    assign beat_o    = beat_slice(line_q, 2'd0);

    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = line_i;
        end else if (shift_i) begin
            line_d = shifted_o;
        end
    end

    always_ff @(posedge clk_i) begin
        line_q <= line_d;
    end

endmodule

// File: rtl/ram_line_xfer.sv
// ---------------------------------------------------------------------------
// ram_line_xfer
// Converts one cache-line request (read fill or write-back) into a 4-beat
// 16-bit RAM burst and, for reads, reassembles the returned beats into a line.
// Ports:
//   ram_clk, ram_rst_n      clock / asynchronous active-low reset
//   req_valid/req_ready     single-request handshake from the cache
//   req_rnw, req_addr       direction (1 = read) and line address
//   req_wdata               write-back line
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata               last completed read line (held)
//   rsp_err                 ack timeout, qualified by rsp_valid
//   ram_avalid              one-cycle address strobe after accept
//   ram_rnw, ram_addr       burst direction / address, held until next accept
//   ram_wdata               write beat (0 outside the write beats)
//   ram_rdata, ram_ack      read beat / RAM acknowledge
// Optional feature: define RAM_LINE_XFER_TIMEOUT_EN to enable the ack
// watchdog (TIMEOUT_CYCLES wait cycles -> response with rsp_err=1).
// Without it rsp_err is 0 and the engine waits for ack indefinitely.
// ---------------------------------------------------------------------------
module ram_line_xfer
    import ram_line_xfer_pkg::*;
#(
    parameter int RAM_ADDR_SIZE  = 13,
    parameter int RAM_WORD_SIZE  = 16,
    parameter int LINE_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     ram_clk,
    input  logic                     ram_rst_n,
    input  logic                     req_valid,
    input  logic                     req_rnw,
    input  logic [RAM_ADDR_SIZE-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0]    req_wdata,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [LINE_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     ram_avalid,
    output logic                     ram_rnw,
    output logic [RAM_ADDR_SIZE-1:0] ram_addr,
    output logic [RAM_WORD_SIZE-1:0] ram_wdata,
    input  logic [RAM_WORD_SIZE-1:0] ram_rdata,
    input  logic                     ram_ack
);

`ifdef RAM_LINE_XFER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    // Last count value before the watchdog fires.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    xfer_state_e state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [7:0]               tcnt_q, tcnt_d;
    logic                     err_q, err_d;
    logic                     avalid_q, avalid_d;
    logic                     rnw_q, rnw_d;
    logic [RAM_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;

    logic                     load;
    logic                     shift;
    logic [WORD_W-1:0]        beat_out;
    logic [LINE_W-1:0]        line_shifted;

    ram_line_beat_shift u_shift (
        .clk_i     (ram_clk),
        .load_i    (load),
        .shift_i   (shift),
        .line_i    (req_wdata),
        .beat_i    (ram_rdata),
        .beat_o    (beat_out),
        .shifted_o (line_shifted)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        err_d       = err_q;
        avalid_d    = 1'b0;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        rsp_rdata_d = rsp_rdata_q;
        load        = 1'b0;
        shift       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    load     = 1'b1;
                    avalid_d = 1'b1;
                    rnw_d    = req_rnw;
                    addr_d   = req_addr;
                    cnt_d    = '0;
                    tcnt_d   = '0;
                    err_d    = 1'b0;
                    state_d  = req_rnw ? S_RD_WAIT : S_WR_BEATS;
                end
            end
            S_WR_BEATS: begin
                // Beat 0 is already on ram_wdata in the avalid cycle.
                shift = 1'b1;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_BEAT) begin
                    tcnt_d  = '0;
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_WAIT, S_RD_WAIT: begin
                if (ram_ack) begin
                    if (state_q == S_RD_WAIT) begin
                        // The ack cycle carries beat 0.
                        shift   = 1'b1;
                        cnt_d   = cnt_q + 2'd1;
                        state_d = S_RD_BEATS;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (TO_EN && (tcnt_q == TO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_RD_BEATS: begin
                // Beats follow back-to-back; ack level is not looked at here.
                shift = 1'b1;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_BEAT) begin
                    rsp_rdata_d = line_shifted;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            err_q       <= 1'b0;
            avalid_q    <= 1'b0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            err_q       <= err_d;
            avalid_q    <= avalid_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_err    = TO_EN && (state_q == S_RESP) && err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign ram_avalid = avalid_q;
    assign ram_rnw    = rnw_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = (state_q == S_WR_BEATS) ? beat_out : '0;

endmodule

// File: tb/tb_ram_line_xfer.sv
module tb_ram_line_xfer;

    localparam int TO_CYC = 255;

    logic        ram_clk = 1'b0;
    logic        ram_rst_n;
    logic        req_valid;
    logic        req_rnw;
    logic [12:0] req_addr;
    logic [63:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_avalid;
    logic        ram_rnw;
    logic [12:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_ack;

    ram_line_xfer #(
        .RAM_ADDR_SIZE (13),
        .RAM_WORD_SIZE (16),
        .LINE_WIDTH    (64),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .ram_clk   (ram_clk),
        .ram_rst_n (ram_rst_n),
        .req_valid (req_valid),
        .req_rnw   (req_rnw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_avalid(ram_avalid),
        .ram_rnw   (ram_rnw),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack)
    );

    always #5 ram_clk = ~ram_clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] last_rd;               // line rsp_rdata must currently hold
    logic [63:0] mem [logic [12:0]];    // RAM contents

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ram_clk);
        #1;
    endtask

    task automatic do_reset();
        ram_rst_n = 1'b0;
        repeat (2) step();
        ram_rst_n = 1'b1;
        last_rd   = '0;
        step();
    endtask

    // One line transfer with the RAM model. dly = idle wait-state cycles
    // before ack (negative = RAM never acks). spur = stray acks during the
    // write beats. b2b = present the next request while the response is out.
    task automatic xfer(input bit rnw, input logic [12:0] addr, input logic [63:0] wd,
                        input int dly, input bit spur, input bit b2b,
                        input bit n_rnw, input logic [12:0] n_addr, input logic [63:0] n_wd);
        int          cyc, ack_cyc, exp_rsp, entry, bound, w;
        bit          done;
        logic [63:0] line, got_w;
        w = 0;
        while (!req_ready && w < 50) begin
            step();
            w++;
        end
        chk("req_ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_rnw   = rnw;
        req_addr  = addr;
        req_wdata = wd;
        line      = '0;
        if (rnw) begin
            if (!mem.exists(addr)) mem[addr] = {$urandom, $urandom};
            line = mem[addr];
        end
        // Wait state begins right after accept for reads, after 4 beats for writes.
        entry = rnw ? 1 : 5;
        if (dly >= 0) begin
            ack_cyc = entry + dly;
            exp_rsp = rnw ? ack_cyc + 4 : ack_cyc + 1;
        end else begin
            ack_cyc = -100;
`ifdef RAM_LINE_XFER_TIMEOUT_EN
            exp_rsp = entry + TO_CYC;
`else
            exp_rsp = -1;
`endif
        end
        bound = ((exp_rsp > 0) ? exp_rsp : entry + 300) + 5;
        got_w = '0;
        done  = 1'b0;
        step();
        req_valid = 1'b0;
        req_rnw   = 1'($urandom);
        req_addr  = 13'($urandom);
        req_wdata = {$urandom, $urandom};
        cyc = 1;
        while (!done && cyc <= bound) begin
            chk("ram_avalid", ram_avalid, (cyc == 1));
            chk("ram_addr", ram_addr, addr);
            chk("ram_rnw", ram_rnw, rnw);
            if (!rnw && cyc <= 5) chk("ram_wdata", ram_wdata, (cyc <= 4) ? wd[16*(cyc-1) +: 16] : 16'h0);
            if (!rnw && cyc <= 4) got_w[16*(cyc-1) +: 16] = ram_wdata;
            if (rsp_valid) begin
                done = 1'b1;
                chk("rsp_cycle", cyc, exp_rsp);
                chk("rsp_err", rsp_err, (dly < 0));
                if (rnw && dly >= 0) last_rd = line;
                chk("rsp_rdata", rsp_rdata, last_rd);
                if (!rnw && dly >= 0) begin
                    mem[addr] = got_w;
                    chk("backdoor_line", got_w, wd);
                end
            end else if (rnw) begin
                chk("rdata_hold", rsp_rdata, last_rd);
            end
            // RAM side for the coming edge
            ram_ack   = 1'b0;
            ram_rdata = 16'($urandom);
            if (done) begin
                ram_ack = 1'($urandom);
                if (b2b) begin
                    req_valid = 1'b1;
                    req_rnw   = n_rnw;
                    req_addr  = n_addr;
                    req_wdata = n_wd;
                end
            end else if (cyc == ack_cyc) begin
                ram_ack = 1'b1;
                if (rnw) ram_rdata = line[15:0];
            end else if (rnw && dly >= 0 && cyc > ack_cyc && cyc <= ack_cyc + 3) begin
                ram_rdata = line[16*(cyc-ack_cyc) +: 16];
                ram_ack   = 1'($urandom);
            end else if (spur && !rnw && cyc >= 2 && cyc <= 4) begin
                ram_ack = 1'b1;
            end
            step();
            cyc++;
        end
        if (exp_rsp > 0) chk("rsp_seen", done, 1);
        else             chk("no_rsp", done, 0);
        if (done) begin
            chk("rsp_pulse", rsp_valid, 0);
            chk("req_ready_after", req_ready, 1);
            chk("no_accept_in_resp", ram_avalid, 0);
        end
    endtask

    bit          r_a [16];
    logic [12:0] a_a [16];
    logic [63:0] d_a [16];
    int          y_a [16];

    initial begin
        int nxt, seen;
        ram_rst_n = 1'b0;
        req_valid = 1'b0;
        req_rnw   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        ram_rdata = '0;
        ram_ack   = 1'b0;
        last_rd   = '0;
        repeat (3) step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ram_avalid", ram_avalid, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        ram_rst_n = 1'b1;
        step();
        chk("idle_wdata", ram_wdata, 0);

        // Directed read
        mem[13'h0ABC] = 64'h0003_0002_0001_6000;
        xfer(1'b1, 13'h0ABC, 64'h0, 2, 1'b0, 1'b0, 1'b0, 13'h0, 64'h0);
        chk("tp_read_line", rsp_rdata, 64'h0003000200016000);

        // Directed write
        xfer(1'b0, 13'h1DE6, 64'hdeadbeef10009bbc, 0, 1'b0, 1'b0, 1'b0, 13'h0, 64'h0);
        chk("tp_write_backdoor", mem[13'h1DE6], 64'hdeadbeef10009bbc);

        // Stray acks during write beats, real ack 10 cycles later
        xfer(1'b0, 13'h0042, 64'h0123456789abcdef, 10, 1'b1, 1'b0, 1'b0, 13'h0, 64'h0);

        // Back-to-back: next request held during the response cycle
        xfer(1'b1, 13'h1DE6, 64'h0, 1, 1'b0, 1'b1, 1'b0, 13'h0077, 64'hcafef00d5555aaaa);
        xfer(1'b0, 13'h0077, 64'hcafef00d5555aaaa, 3, 1'b0, 1'b0, 1'b0, 13'h0, 64'h0);

        // Randomized mix
        for (int i = 0; i < 16; i++) begin
            r_a[i] = 1'($urandom);
            a_a[i] = 13'h0100 + 13'($urandom_range(0, 3));
            d_a[i] = {$urandom, $urandom};
            y_a[i] = $urandom_range(0, 5);
        end
        for (int i = 0; i < 16; i++) begin
            nxt = (i < 15) ? i + 1 : i;
            xfer(r_a[i], a_a[i], d_a[i], y_a[i], 1'($urandom), (i < 15) && 1'($urandom),
                 r_a[nxt], a_a[nxt], d_a[nxt]);
        end

        // Reset during the read beats
        mem[13'h0555] = 64'h1111_2222_3333_4444;
        req_valid = 1'b1;
        req_rnw   = 1'b1;
        req_addr  = 13'h0555;
        step();
        req_valid = 1'b0;
        ram_ack   = 1'b1;
        ram_rdata = 16'h4444;
        step();
        ram_ack   = 1'b0;
        ram_rdata = 16'h3333;
        step();
        ram_rdata = 16'h2222;
        #2;
        ram_rst_n = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 1);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_ram_addr", ram_addr, 0);
        chk("arst_ram_rnw", ram_rnw, 0);
        chk("arst_rsp_rdata", rsp_rdata, 0);
        last_rd = '0;
        repeat (2) step();
        ram_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        chk("arst_no_rsp", seen, 0);
        xfer(1'b1, 13'h0555, 64'h0, 0, 1'b0, 1'b0, 1'b0, 13'h0, 64'h0);

        // RAM never acks
        xfer(1'b0, 13'h0900, 64'h5a5a5a5a5a5a5a5a, -1, 1'b0, 1'b0, 1'b0, 13'h0, 64'h0);
        do_reset();
        chk("post_to_ready", req_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
